// File: rtl/path_reader.sv
// -----------------------------------------------------------------------------
// path_reader
//
// Drains a stack/queue storage component from its queue end and hands each
// element to a downstream consumer over a valid/ready handshake.
//
// One element takes LOAD -> SEND -> ADV (3 cycles minimum with outReady=1).
// LOAD captures the storage element and whether it is the last one. SEND
// holds the element until the consumer accepts it. ADV pulses readSignal so
// the storage advances its queue pointer, or wraps it to 0 after the last
// element. FIN pulses finished for one cycle and returns to IDLE.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   drain request, honoured only in IDLE
//   isEmpty    in   storage empty flag, sampled in IDLE on start
//   done       in   current queue element is the last one, sampled in LOAD
//   qeueuData  in   [1:0] storage element at the queue pointer
//   readSignal out  one-cycle pulse in ADV, advances/wraps the queue pointer
//   outDir     out  [1:0] element presented downstream
//   outValid   out  outDir is valid (SEND only)
//   outReady   in   downstream accepts outDir when outValid=1
//   busy       out  high in every state except IDLE
//   finished   out  one-cycle pulse in FIN
//   count      out  [8:0] elements delivered in the current/last drain
// -----------------------------------------------------------------------------
module path_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       isEmpty,
  input  logic       done,
  input  logic [1:0] qeueuData,
  output logic       readSignal,
  output logic [1:0] outDir,
  output logic       outValid,
  input  logic       outReady,
  output logic       busy,
  output logic       finished,
  output logic [8:0] count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_ADV  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [8:0] COUNT_MAX = 9'd256;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_out_dir;
  logic [1:0] w_out_dir_next;
  logic       r_last;
  logic       w_last_next;
  logic [8:0] r_count;
  logic [8:0] w_count_next;
  logic       r_read;
  logic       r_valid;
  logic       r_busy;
  logic       r_finished;

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_next   = r_state;
    w_out_dir_next = r_out_dir;
    w_last_next    = r_last;
    w_count_next   = r_count;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_count_next = 9'd0;
          // An empty storage still produces a finished pulse so the
          // requester always sees a completion.
          w_state_next = isEmpty ? S_FIN : S_LOAD;
        end
      end

      S_LOAD: begin
        w_out_dir_next = qeueuData;
        w_last_next    = done;
        w_state_next   = S_SEND;
      end

      S_SEND: begin
        // outValid is registered high for the whole SEND state, so the
        // handshake reduces to outReady here.
        if (outReady) begin
          // Storage holds at most 256 elements; the guard keeps count from
          // ever wrapping even if the storage misreports done.
          if (r_count != COUNT_MAX) begin
            w_count_next = r_count + 9'd1;
          end
          w_state_next = S_ADV;
        end
      end

      S_ADV: begin
        w_state_next = r_last ? S_FIN : S_LOAD;
      end

      S_FIN: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs. Outputs are decoded from the
  // next state so they are flop outputs that line up with the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_out_dir  <= 2'b00;
      r_last     <= 1'b0;
      r_count    <= 9'd0;
      r_read     <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_out_dir  <= w_out_dir_next;
      r_last     <= w_last_next;
      r_count    <= w_count_next;
      r_read     <= (w_state_next == S_ADV);
      r_valid    <= (w_state_next == S_SEND);
      r_busy     <= (w_state_next != S_IDLE);
      r_finished <= (w_state_next == S_FIN);
    end
  end

  assign readSignal = r_read;
  assign outDir     = r_out_dir;
  assign outValid   = r_valid;
  assign busy       = r_busy;
  assign finished   = r_finished;
  assign count      = r_count;

endmodule
